// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU command sequencer.
// Holds the command opcode encoding, the FSM state type and the
// register-index width used by the sequencer and its register file.
package alu_seq_pkg;

    localparam int REG_IDX_W = 2;
    localparam int NUM_REGS  = 4;

    localparam logic [2:0] CMD_ADD = 3'b000;
    localparam logic [2:0] CMD_SUB = 3'b001;
    localparam logic [2:0] CMD_AND = 3'b010;
    localparam logic [2:0] CMD_INC = 3'b011;
    localparam logic [2:0] CMD_LDI = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 4-entry operand register file for the ALU sequencer.
// Two combinational read ports feed the ALU operands; the single write
// port commits results on the clock edge. Everything clears to zero on
// an asynchronous active-low reset.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [REG_IDX_W-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [REG_IDX_W-1:0]  raddr_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic [REG_IDX_W-1:0]  raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Storage: clear all entries on reset, otherwise write one entry when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: turns the combinational 2-bit-opcode ALU into a
// sequential execute unit. Commands arrive over valid/ready; ALU ops go
// IDLE -> ISSUE -> WB, LDI goes IDLE -> WB, illegal opcodes are dropped.
// Optional feature macro: ALU_SEQ_FLAGS_EN adds registered flag_z/flag_n.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [1:0]            cmd_dst,
    input  logic [1:0]            cmd_src_a,
    input  logic [1:0]            cmd_src_b,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic [1:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  res_valid,
    output logic [1:0]            res_dst,
    output logic [DATA_WIDTH-1:0] res_data
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic                  flag_z,
    output logic                  flag_n
`endif
);

    state_t state, state_next;

    logic [1:0]            lat_alu_op;
    logic [1:0]            lat_dst;
    logic [1:0]            lat_src_a;
    logic [1:0]            lat_src_b;
    logic [DATA_WIDTH-1:0] result;

    logic                  accept;
    logic                  is_alu_cmd;
    logic                  is_ldi;
    logic                  rf_we;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    assign accept     = cmd_valid & cmd_ready;
    assign is_alu_cmd = (cmd_op[2] == 1'b0);
    assign is_ldi     = (cmd_op == CMD_LDI);

    alu_seq_regfile #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (lat_dst),
        .wdata   (result),
        .raddr_a (lat_src_a),
        .rdata_a (rd_a),
        .raddr_b (lat_src_b),
        .rdata_b (rd_b)
    );

    // State register; reset aborts any command in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and all handshake, ALU-drive and writeback outputs
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        alu_op     = 2'b00;
        alu_a      = '0;
        alu_b      = '0;
        res_valid  = 1'b0;
        res_dst    = 2'b00;
        res_data   = '0;
        rf_we      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = rst_n;
                if (cmd_valid && rst_n) begin
                    if (is_alu_cmd) begin
                        state_next = ST_ISSUE;
                    end else if (is_ldi) begin
                        state_next = ST_WB;
                    end
                end
            end
            ST_ISSUE: begin
                alu_op     = lat_alu_op;
                alu_a      = rd_a;
                alu_b      = rd_b;
                state_next = ST_WB;
            end
            ST_WB: begin
                res_valid  = 1'b1;
                res_dst    = lat_dst;
                res_data   = result;
                rf_we      = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Command fields are captured at the handshake; the result register
    // takes the immediate for LDI or the ALU output at the end of ISSUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_alu_op <= 2'b00;
            lat_dst    <= 2'b00;
            lat_src_a  <= 2'b00;
            lat_src_b  <= 2'b00;
            result     <= '0;
        end else if (accept) begin
            lat_alu_op <= cmd_op[1:0];
            lat_dst    <= cmd_dst;
            lat_src_a  <= cmd_src_a;
            lat_src_b  <= cmd_src_b;
            if (is_ldi) begin
                result <= cmd_imm;
            end
        end else if (state == ST_ISSUE) begin
            result <= alu_result;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    // Zero/negative flags follow the value written back and hold in between
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (res_valid) begin
            flag_z <= (res_data == '0);
            flag_n <= res_data[DATA_WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: self-checking bench for alu_cmd_sequencer.
// A behavioural ALU drives alu_result; a register-array reference model
// predicts operands, writeback values and (with ALU_SEQ_FLAGS_EN) flags.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_src_a;
    logic [1:0] cmd_src_b;
    logic [7:0] cmd_imm;
    logic [1:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic       res_valid;
    logic [1:0] res_dst;
    logic [7:0] res_data;
`ifdef ALU_SEQ_FLAGS_EN
    logic       flag_z;
    logic       flag_n;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] model_rf [4];
    logic       exp_z;
    logic       exp_n;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_dst    (cmd_dst),
        .cmd_src_a  (cmd_src_a),
        .cmd_src_b  (cmd_src_b),
        .cmd_imm    (cmd_imm),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_dst    (res_dst),
        .res_data   (res_data)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .flag_z     (flag_z),
        .flag_n     (flag_n)
`endif
    );

    // Behavioural stand-in for the downstream combinational ALU
    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a - alu_b;
            2'b10: alu_result = alu_a & alu_b;
            2'b11: alu_result = alu_a + 8'd1;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic logic [7:0] refCompute(input logic [2:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input logic [7:0] imm);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a + 8'd1;
            3'd4:    return imm;
            default: return 8'h00;
        endcase
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 4; i++) model_rf[i] = 8'h00;
        exp_z = 1'b0;
        exp_n = 1'b0;
    endtask

    task automatic waitReady();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("wait_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Issue one command and follow it through to its return to IDLE.
    // Called and returns at 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] dst,
                                 input logic [1:0] sa, input logic [1:0] sb,
                                 input logic [7:0] imm);
        logic [7:0] a_val;
        logic [7:0] b_val;
        logic [7:0] expv;
        waitReady();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src_a = sa;
        cmd_src_b = sb;
        cmd_imm   = imm;
        a_val     = model_rf[sa];
        b_val     = model_rf[sb];
        expv      = refCompute(op, a_val, b_val, imm);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_imm   = 8'($urandom);
        if (op <= 3'd3) begin
            checkOutput("issue_alu_op", {30'd0, alu_op}, {30'd0, op[1:0]});
            checkOutput("issue_alu_a", {24'd0, alu_a}, {24'd0, a_val});
            checkOutput("issue_alu_b", {24'd0, alu_b}, {24'd0, b_val});
            checkOutput("issue_ready", {31'd0, cmd_ready}, 32'd0);
            checkOutput("issue_res_valid", {31'd0, res_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        if (op <= 3'd4) begin
            checkOutput("wb_res_valid", {31'd0, res_valid}, 32'd1);
            checkOutput("wb_res_dst", {30'd0, res_dst}, {30'd0, dst});
            checkOutput("wb_res_data", {24'd0, res_data}, {24'd0, expv});
            checkOutput("wb_ready", {31'd0, cmd_ready}, 32'd0);
            checkOutput("wb_alu_a", {24'd0, alu_a}, 32'd0);
            model_rf[dst] = expv;
            exp_z = (expv == 8'h00);
            exp_n = expv[7];
            @(posedge clk);
            #1;
            checkOutput("post_wb_res_valid", {31'd0, res_valid}, 32'd0);
            checkOutput("post_wb_ready", {31'd0, cmd_ready}, 32'd1);
`ifdef ALU_SEQ_FLAGS_EN
            checkOutput("flag_z", {31'd0, flag_z}, {31'd0, exp_z});
            checkOutput("flag_n", {31'd0, flag_n}, {31'd0, exp_n});
`endif
        end else begin
            checkOutput("illegal_res_valid", {31'd0, res_valid}, 32'd0);
            checkOutput("illegal_ready", {31'd0, cmd_ready}, 32'd1);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        checkOutput({tag, "_res_dst"}, {30'd0, res_dst}, 32'd0);
        checkOutput({tag, "_res_data"}, {24'd0, res_data}, 32'd0);
        checkOutput({tag, "_alu_op"}, {30'd0, alu_op}, 32'd0);
        checkOutput({tag, "_alu_a"}, {24'd0, alu_a}, 32'd0);
        checkOutput({tag, "_alu_b"}, {24'd0, alu_b}, 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
        checkOutput({tag, "_flag_z"}, {31'd0, flag_z}, 32'd0);
        checkOutput({tag, "_flag_n"}, {31'd0, flag_n}, 32'd0);
`endif
    endtask

    // Watchdog so the run always ends even if the DUT wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed scenarios, mid-command reset, random traffic
    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_dst   = 2'd0;
        cmd_src_a = 2'd0;
        cmd_src_b = 2'd0;
        cmd_imm   = 8'h00;
        clearModel();

        #3;
        checkOutput("rst_ready_low", {31'd0, cmd_ready}, 32'd0);
        checkResetOutputs("rst");
        #19;
        rst_n = 1'b1;
        #1;
        checkOutput("rel_ready_high", {31'd0, cmd_ready}, 32'd1);
        checkResetOutputs("rel");
        @(posedge clk);
        #1;

        applyStimulus(3'd4, 2'd0, 2'd0, 2'd0, 8'h05);
        applyStimulus(3'd4, 2'd1, 2'd0, 2'd0, 8'h03);
        applyStimulus(3'd0, 2'd2, 2'd0, 2'd1, 8'h00);
        applyStimulus(3'd1, 2'd3, 2'd1, 2'd0, 8'h00);
        applyStimulus(3'd4, 2'd0, 2'd0, 2'd0, 8'hFF);
        applyStimulus(3'd3, 2'd0, 2'd0, 2'd0, 8'h00);
        applyStimulus(3'd2, 2'd1, 2'd0, 2'd0, 8'h00);
        applyStimulus(3'd6, 2'd2, 2'd0, 2'd0, 8'hAA);
        applyStimulus(3'd0, 2'd3, 2'd2, 2'd2, 8'h00);

        waitReady();
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_dst   = 2'd2;
        cmd_src_a = 2'd2;
        cmd_src_b = 2'd3;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checkOutput("abort_issue_alu_a", {24'd0, alu_a}, {24'd0, model_rf[2]});
        rst_n = 1'b0;
        clearModel();
        #1;
        checkOutput("abort_ready_low", {31'd0, cmd_ready}, 32'd0);
        checkResetOutputs("abort");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("abort_rel_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("abort_no_wb", {31'd0, res_valid}, 32'd0);
        applyStimulus(3'd0, 2'd0, 2'd2, 2'd3, 8'h00);
        applyStimulus(3'd4, 2'd1, 2'd0, 2'd0, 8'h5A);
        applyStimulus(3'd0, 2'd2, 2'd1, 2'd1, 8'h00);

        for (int k = 0; k < 80; k++) begin
            applyStimulus(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom),
                          2'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
